out_channel_serializer: RTL and testbench

- Drains the program's output channel.
- The executing program pushes one word per out instruction into an NOut-deep buffer.
- The block serializes buffered words LSB-first onto a one-bit line with a frame strobe, with a consumer stall input.
- It is the transmit end of the output channel and sits between the fpga program core and the board-level test pins.

---
 rtl/out_channel_pkg.sv | 22 ++
 rtl/out_channel_fifo.sv | 67 ++++++
 rtl/out_channel_serializer.sv | 130 +++++++++++++
 tb/tb_out_channel_serializer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_channel_pkg.sv
// Shared types, default sizes and frame-length helper for the output channel serializer.
// The frame length grows by one parity bit when OUT_PARITY_EN is defined.
package out_channel_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH     = 12;
    localparam int DEFAULT_NOUT      = 8;
    localparam int DEFAULT_NOUT_BITS = 3;

    function automatic int frame_len(input int width);
`ifdef OUT_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/out_channel_fifo.sv
// Circular word buffer feeding the serializer, with registered full flag and sticky overflow.
module out_channel_fifo
    import out_channel_pkg::*;
#(
    parameter int W  = DEFAULT_WIDTH,
    parameter int N  = DEFAULT_NOUT,
    parameter int NB = DEFAULT_NOUT_BITS
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [NB:0]   count,
    output logic          full,
    output logic          overflow,
    output logic          empty_next
);

    logic [W-1:0]  mem [N];
    logic [NB-1:0] wr_ptr;
    logic [NB-1:0] rd_ptr;
    logic [NB:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign do_push    = push && !full;
    assign do_pop     = pop && (count != '0);
    assign head       = mem[rd_ptr];
    assign empty_next = (count_next == '0);

    // Occupancy after this edge; simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (NB+1)'(1);
            2'b01:   count_next = count - (NB+1)'(1);
            default: count_next = count;
        endcase
    end

    // Storage array; contents are don't-care until written so it carries no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because N is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + NB'(1);
            if (do_pop)  rd_ptr <= rd_ptr + NB'(1);
            count    <= count_next;
            full     <= (count_next == (NB+1)'(N));
            overflow <= overflow || (push && full);
        end
    end

endmodule

// File: rtl/out_channel_serializer.sv
// Transmit end of the program output channel: buffers pushed words and shifts them out LSB-first.
// Optional macro OUT_PARITY_EN appends an even-parity bit to every frame.
module out_channel_serializer
    import out_channel_pkg::*;
#(
    parameter int MemoryElementWidth = DEFAULT_WIDTH,
    parameter int NOut               = DEFAULT_NOUT,
    parameter int NOutBits           = DEFAULT_NOUT_BITS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          outWrite,
    input  logic [MemoryElementWidth-1:0] outData,
    output logic                          outFull,
    output logic [NOutBits:0]             outCount,
    output logic                          overflow,
    input  logic                          serialReady,
    output logic                          serialData,
    output logic                          serialFrame,
    output logic                          drained
);

    localparam int W  = MemoryElementWidth;
    localparam int FL = frame_len(W);
    localparam int CW = $clog2(FL + 1);

    state_t          state;
    state_t          state_next;
    logic [FL-1:0]   shift_reg;
    logic [FL-1:0]   shift_next;
    logic [CW-1:0]   bit_cnt;
    logic [CW-1:0]   bit_cnt_next;
    logic [FL-1:0]   load_word;
    logic [W-1:0]    head;
    logic            pop;
    logic            empty_next;

    out_channel_fifo #(
        .W  (W),
        .N  (NOut),
        .NB (NOutBits)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (outWrite),
        .push_data  (outData),
        .pop        (pop),
        .head       (head),
        .count      (outCount),
        .full       (outFull),
        .overflow   (overflow),
        .empty_next (empty_next)
    );

`ifdef OUT_PARITY_EN
    function automatic logic even_parity(input logic [W-1:0] d);
        return ^d;
    endfunction

    // Parity sits above the data so it falls out after the last data bit.
    assign load_word = {even_parity(head), head};
`else
    assign load_word = head;
`endif

    // Next-state, shift and pop decisions; the reload choice is made on the final frame bit.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (outCount != '0) begin
                    pop          = 1'b1;
                    shift_next   = load_word;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end else begin
                    state_next   = IDLE;
                end
            end
            SHIFT: begin
                if (serialReady) begin
                    if (bit_cnt == CW'(FL - 1)) begin
                        if (outCount != '0) begin
                            pop          = 1'b1;
                            shift_next   = load_word;
                            bit_cnt_next = '0;
                        end else begin
                            shift_next   = '0;
                            bit_cnt_next = '0;
                            state_next   = IDLE;
                        end
                    end else begin
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt + CW'(1);
                    end
                end else begin
                    state_next = SHIFT;
                end
            end
            default: begin
                state_next   = IDLE;
                shift_next   = '0;
                bit_cnt_next = '0;
            end
        endcase
    end

    // Serial state and registered outputs, all derived from next-state values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            serialData  <= 1'b0;
            serialFrame <= 1'b0;
            drained     <= 1'b1;
        end else begin
            state       <= state_next;
            shift_reg   <= shift_next;
            bit_cnt     <= bit_cnt_next;
            serialData  <= (state_next == SHIFT) ? shift_next[0] : 1'b0;
            serialFrame <= (state_next == SHIFT);
            drained     <= empty_next && (state_next == IDLE);
        end
    end

endmodule

// File: tb/tb_out_channel_serializer.sv
// Directed self-checking bench for out_channel_serializer (default W=12, NOut=8).
// Parity checks are compiled in when OUT_PARITY_EN is defined.
module tb_out_channel_serializer;

    localparam int W = 12;
`ifdef OUT_PARITY_EN
    localparam int FL = 13;
`else
    localparam int FL = 12;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          outWrite = 1'b0;
    logic [W-1:0]  outData = '0;
    logic          outFull;
    logic [3:0]    outCount;
    logic          overflow;
    logic          serialReady = 1'b1;
    logic          serialData;
    logic          serialFrame;
    logic          drained;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [255:0] stream;
    int           idx;
    int           maxc;
    bit           seen_end;
    bit           gap;

    out_channel_serializer dut (
        .clock       (clock),
        .reset       (reset),
        .outWrite    (outWrite),
        .outData     (outData),
        .outFull     (outFull),
        .outCount    (outCount),
        .overflow    (overflow),
        .serialReady (serialReady),
        .serialData  (serialData),
        .serialFrame (serialFrame),
        .drained     (drained)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stream();
        stream   = '0;
        idx      = 0;
        maxc     = 0;
        seen_end = 1'b0;
        gap      = 1'b0;
    endtask

    task automatic sample();
        if (int'(outCount) > maxc) maxc = int'(outCount);
        if (serialFrame) begin
            if (seen_end) gap = 1'b1;
            if (idx < 256) stream[idx] = serialData;
            idx++;
        end else if (idx > 0) begin
            seen_end = 1'b1;
        end
    endtask

    function automatic logic [W-1:0] word_at(input int j);
        return stream[j*FL +: W];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total_cnt++;
        if ({outFull, outCount, overflow, serialData, serialFrame, drained} !== 9'b0_0000_0_0_0_1) begin
            $display("FAIL reset_state: got full=%0b cnt=%0d ovf=%0b data=%0b frame=%0b drained=%0b, want 0 0 0 0 0 1",
                     outFull, outCount, overflow, serialData, serialFrame, drained);
        end else pass_cnt++;
        #2 reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        clear_stream();
        serialReady = 1'b1;
        outWrite = 1'b1;
        outData  = 12'h002;
        step();
        outWrite = 1'b0;
        total_cnt++;
        if ({outCount, serialFrame, drained} !== {4'd1, 1'b0, 1'b0}) begin
            $display("FAIL single_push_latency: got cnt=%0d frame=%0b drained=%0b, want 1 0 0", outCount, serialFrame, drained);
        end else pass_cnt++;
        step();
        total_cnt++;
        if ({serialFrame, serialData, outCount} !== {1'b1, 1'b0, 4'd0}) begin
            $display("FAIL single_frame_start: got frame=%0b data=%0b cnt=%0d, want 1 0 0", serialFrame, serialData, outCount);
        end else pass_cnt++;
        sample();
        repeat (FL + 3) begin
            step();
            sample();
        end
        total_cnt++;
        if (idx !== FL || gap !== 1'b0) begin
            $display("FAIL single_frame_len: got %0d bits gap=%0b, want %0d bits gap=0", idx, gap, FL);
        end else pass_cnt++;
        total_cnt++;
        if (word_at(0) !== 12'h002) begin
            $display("FAIL single_word: got %h, want 002", word_at(0));
        end else pass_cnt++;
        total_cnt++;
        if (drained !== 1'b1) begin
            $display("FAIL single_drained: got %0b, want 1", drained);
        end else pass_cnt++;
`ifdef OUT_PARITY_EN
        total_cnt++;
        if (stream[12] !== 1'b1) begin
            $display("FAIL single_parity: got %0b, want 1", stream[12]);
        end else pass_cnt++;
`endif
    endtask

    task automatic test_back_to_back();
        clear_stream();
        serialReady = 1'b1;
        outWrite = 1'b1;
        outData  = 12'h004;
        step();
        sample();
        outData = 12'h005;
        step();
        sample();
        outData = 12'h006;
        step();
        sample();
        outWrite = 1'b0;
        repeat (3*FL + 3) begin
            step();
            sample();
        end
        total_cnt++;
        if (idx !== 3*FL || gap !== 1'b0) begin
            $display("FAIL b2b_frame: got %0d bits gap=%0b, want %0d bits gap=0", idx, gap, 3*FL);
        end else pass_cnt++;
        total_cnt++;
        if ({word_at(0), word_at(1), word_at(2)} !== {12'h004, 12'h005, 12'h006}) begin
            $display("FAIL b2b_words: got %h %h %h, want 004 005 006", word_at(0), word_at(1), word_at(2));
        end else pass_cnt++;
        total_cnt++;
        if (maxc !== 2) begin
            $display("FAIL b2b_peak_count: got %0d, want 2", maxc);
        end else pass_cnt++;
    endtask

    task automatic test_overflow();
        clear_stream();
        serialReady = 1'b0;
        // The first word leaves the buffer for the shift register, so nine pushes fill it.
        for (int i = 0; i < 9; i++) begin
            outWrite = 1'b1;
            outData  = 12'h100 + 12'(i);
            step();
        end
        outWrite = 1'b0;
        total_cnt++;
        if ({outFull, outCount, overflow, serialFrame, serialData} !== {1'b1, 4'd8, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL full_state: got full=%0b cnt=%0d ovf=%0b frame=%0b data=%0b, want 1 8 0 1 0",
                     outFull, outCount, overflow, serialFrame, serialData);
        end else pass_cnt++;
        outWrite = 1'b1;
        outData  = 12'hBAD;
        step();
        outWrite = 1'b0;
        total_cnt++;
        if ({overflow, outCount, outFull} !== {1'b1, 4'd8, 1'b1}) begin
            $display("FAIL overflow_set: got ovf=%0b cnt=%0d full=%0b, want 1 8 1", overflow, outCount, outFull);
        end else pass_cnt++;
        serialReady = 1'b1;
        sample();
        repeat (9*FL + 5) begin
            step();
            sample();
        end
        total_cnt++;
        if (idx !== 9*FL || gap !== 1'b0) begin
            $display("FAIL overflow_drain_len: got %0d bits gap=%0b, want %0d bits gap=0", idx, gap, 9*FL);
        end else pass_cnt++;
        for (int j = 0; j < 9; j++) begin
            total_cnt++;
            if (word_at(j) !== 12'h100 + 12'(j)) begin
                $display("FAIL overflow_word%0d: got %h, want %h", j, word_at(j), 12'h100 + 12'(j));
            end else pass_cnt++;
        end
        total_cnt++;
        if ({overflow, drained, outFull} !== {1'b1, 1'b1, 1'b0}) begin
            $display("FAIL overflow_sticky: got ovf=%0b drained=%0b full=%0b, want 1 1 0", overflow, drained, outFull);
        end else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [15:0] rebuilt;
        int          bad;
        logic        r;
        clear_stream();
        serialReady = 1'b1;
        outWrite = 1'b1;
        outData  = 12'hA5A;
        step();
        outWrite = 1'b0;
        step();
        r = 1'b0;
        repeat (2*FL + 4) begin
            sample();
            serialReady = r;
            step();
            r = ~r;
        end
        serialReady = 1'b1;
        step();
        bad = 0;
        rebuilt = '0;
        for (int k = 0; k < FL; k++) begin
            if (stream[2*k] !== stream[2*k+1]) bad++;
            rebuilt[k] = stream[2*k];
        end
        total_cnt++;
        if (idx !== 2*FL || bad !== 0) begin
            $display("FAIL stall_hold: got %0d samples %0d unheld bits, want %0d samples 0 unheld", idx, bad, 2*FL);
        end else pass_cnt++;
        total_cnt++;
        if (rebuilt[11:0] !== 12'hA5A) begin
            $display("FAIL stall_word: got %h, want a5a", rebuilt[11:0]);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        bit frame_seen;
        serialReady = 1'b1;
        outWrite = 1'b1;
        outData  = 12'hFFF;
        step();
        outData = 12'h111;
        step();
        outData = 12'h222;
        step();
        outData = 12'h333;
        step();
        outWrite = 1'b0;
        step();
        step();
        step();
        total_cnt++;
        if ({serialFrame, serialData, outCount} !== {1'b1, 1'b1, 4'd3}) begin
            $display("FAIL midword_setup: got frame=%0b data=%0b cnt=%0d, want 1 1 3", serialFrame, serialData, outCount);
        end else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({outFull, outCount, overflow, serialData, serialFrame, drained} !== 9'b0_0000_0_0_0_1) begin
            $display("FAIL midword_reset: got full=%0b cnt=%0d ovf=%0b data=%0b frame=%0b drained=%0b, want 0 0 0 0 0 1",
                     outFull, outCount, overflow, serialData, serialFrame, drained);
        end else pass_cnt++;
        #2 reset = 1'b0;
        frame_seen = 1'b0;
        repeat (3*FL) begin
            step();
            if (serialFrame || outCount != 4'd0 || !drained) frame_seen = 1'b1;
        end
        total_cnt++;
        if (frame_seen !== 1'b0) begin
            $display("FAIL midword_no_resume: got activity=%0b, want 0", frame_seen);
        end else pass_cnt++;
    endtask

`ifdef OUT_PARITY_EN
    task automatic test_parity();
        logic [12:0] p1;
        logic [12:0] p2;
        clear_stream();
        serialReady = 1'b1;
        outWrite = 1'b1;
        outData  = 12'h007;
        step();
        outWrite = 1'b0;
        repeat (FL + 3) begin
            step();
            sample();
        end
        p1 = stream[12:0];
        clear_stream();
        outWrite = 1'b1;
        outData  = 12'h003;
        step();
        outWrite = 1'b0;
        repeat (FL + 3) begin
            step();
            sample();
        end
        p2 = stream[12:0];
        total_cnt++;
        if (p1 !== 13'h1007) begin
            $display("FAIL parity_007: got %h, want 1007", p1);
        end else pass_cnt++;
        total_cnt++;
        if (p2 !== 13'h0003 || idx !== FL) begin
            $display("FAIL parity_003: got %h len %0d, want 0003 len %0d", p2, idx, FL);
        end else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_stall();
        test_reset_mid_word();
`ifdef OUT_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
